vx_tcu_drl_excep_apply: RTL and testbench
=========================================

VX_TCU_DRL_EXCEP_APPLY -- requirements
Module: VX_tcu_drl_excep_apply

Interface
REQ-001 SHALL have parameter TAG_W, default 8: width of the opaque tag carried with each result.
REQ-002 SHALL have parameter DEPTH, default 2: output buffer entries; only value 2 is supported.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset sampled on the rising edge of clk.
REQ-005 SHALL have port valid_in, input, 1: upstream FEDP result valid.
REQ-006 SHALL have port ready_in, output, 1: block can accept the input.
REQ-007 SHALL have port fmtf, input, 3: format ID of the operation (TCU_*_ID).
REQ-008 SHALL have port result_in, input, 32: raw FP32 dot-product result.
REQ-009 SHALL have port excep_in, input, fedp_excep_t: sign, is_nan and is_inf flags for the result.
REQ-010 SHALL have port tag_in, input, TAG_W: passthrough tag.
REQ-011 SHALL have port valid_out, output, 1: final result valid.
REQ-012 SHALL have port ready_out, input, 1: downstream accepts the result.
REQ-013 SHALL have port result_out, output, 32: final result after exception override.
REQ-014 SHALL have port tag_out, output, TAG_W: tag of the entry at the buffer head.
REQ-015 SHALL have port clr_stats, input, 1: clears the statistics counters.
REQ-016 SHALL have port nan_cnt, output, 16: saturating count of retired NaN results.
REQ-017 SHALL have port inf_cnt, output, 16: saturating count of retired infinite results.

Function
REQ-018 SHALL accept an input when valid_in and ready_in are both high, and SHALL retire the head entry when valid_out and ready_out are both high.
REQ-019 SHALL, for an FP format (TCU_FP32_ID, TCU_FP16_ID, TCU_BF16_ID, TCU_FP8_ID, TCU_BF8_ID) with excep_in.is_nan set, store 32'h7FC00000 (canonical qNaN, sign ignored).
REQ-020 SHALL, for an FP format with is_inf set and is_nan clear, store {excep_in.sign, 31'h7F800000}.
REQ-021 SHALL give is_nan priority over is_inf when both flags are set.
REQ-022 SHALL store result_in unmodified when neither flag is set, and for any non-FP fmtf regardless of the flags.
REQ-023 SHALL compute the override combinationally at accept and store the overridden value, so result_out is a register output.
REQ-024 SHALL store, per entry, the result, tag, a nan flag and an inf flag; both flags are forced to 0 for non-FP formats.
REQ-025 SHALL drive valid_out high exactly one cycle after an accept into an empty buffer.
REQ-026 SHALL sustain one accept and one retire per cycle.
REQ-027 SHALL hold ready_in low only when both entries are occupied.
REQ-028 SHALL derive ready_in from registered occupancy only, with no combinational path from ready_out.
REQ-029 SHALL, when full and a retire occurs, raise ready_in on the following cycle, not the same cycle.
REQ-030 SHALL retire entries in FIFO order.
REQ-031 SHALL hold result_out and tag_out stable while valid_out is high and ready_out is low.
REQ-032 SHALL add 1 to nan_cnt when a retired entry's nan flag is set, and add 1 to inf_cnt when its inf flag is set.
REQ-033 SHALL saturate both counters at 16'hFFFF.
REQ-034 SHALL set both counters to 0 when clr_stats is high; clr_stats wins over a coincident increment.
REQ-035 SHALL count a retirement in the same cycle as an accept (simultaneous events) exactly once.

Reset
REQ-036 SHALL, on reset, empty the buffer, set valid_out=0, ready_in=1 and nan_cnt=inf_cnt=0, and leave result_out and tag_out don't-care.
REQ-037 SHALL drop in-flight entries on reset mid-operation, with no retire, and ignore inputs in the reset cycle.

Structure
REQ-038 SHALL take fedp_excep_t and the TCU_*_ID constants from VX_tcu_pkg, where they already live.
REQ-039 SHALL place the canonical constants TCU_FP32_QNAN (32'h7FC00000) and TCU_FP32_INF_MAG (31'h7F800000) in VX_tcu_pkg.
REQ-040 SHALL implement the 2-entry buffer as one sub-module, VX_tcu_excep_buf, with internal read/write pointers and count; the override logic stays in the top module.

Verification
REQ-041 Bench SHALL cover: FP16 op, is_nan=1, result_in=32'h3F800000, ready_out=1 -> next cycle result_out=32'h7FC00000, nan_cnt=1.
REQ-042 Bench SHALL cover: BF8 op, is_inf=1, sign=1 -> result_out=32'hFF800000, inf_cnt=1; the same flags with an integer fmtf -> raw result_out and counters unchanged.
REQ-043 Bench SHALL cover: ready_out=0 with 3 back-to-back valids -> ready_in falls after 2 accepts; raise ready_out -> tags 0,1,2 retire in order, and ready_in returns 1 cycle after the first retire.
REQ-044 Bench SHALL cover: nan_cnt preloaded via 65535 NaN retirements, then one more -> 16'hFFFF; clr_stats coincident with a NaN retire -> 0.
REQ-045 Bench SHALL cover: is_nan=1 and is_inf=1 with sign=1 -> 32'h7FC00000, nan_cnt+1, inf_cnt unchanged.
REQ-046 Bench SHALL cover: reset asserted with 2 entries held -> next cycle valid_out=0, ready_in=1, counters 0, and no stale entry after release.

Source files
------------

// File: rtl/vx_tcu_drl_excep_apply_pkg.sv
// Shared TCU definitions: format IDs, FEDP exception flags and canonical
// FP32 special-value encodings used when overriding dot-product results.
package VX_tcu_pkg;

  localparam logic [2:0] TCU_FP32_ID = 3'd0;
  localparam logic [2:0] TCU_FP16_ID = 3'd1;
  localparam logic [2:0] TCU_BF16_ID = 3'd2;
  localparam logic [2:0] TCU_FP8_ID  = 3'd3;
  localparam logic [2:0] TCU_BF8_ID  = 3'd4;
  localparam logic [2:0] TCU_I32_ID  = 3'd5;
  localparam logic [2:0] TCU_I8_ID   = 3'd6;
  localparam logic [2:0] TCU_U8_ID   = 3'd7;

  localparam logic [31:0] TCU_FP32_QNAN    = 32'h7FC00000;
  localparam logic [30:0] TCU_FP32_INF_MAG = 31'h7F800000;

  typedef struct packed {
    logic sign;
    logic is_nan;
    logic is_inf;
  } fedp_excep_t;

  // True for formats whose result is floating point and thus subject to override.
  function automatic logic tcu_is_fp_fmt(input logic [2:0] fmt);
    logic is_fp;
    case (fmt)
      TCU_FP32_ID, TCU_FP16_ID, TCU_BF16_ID,
      TCU_FP8_ID, TCU_BF8_ID: is_fp = 1'b1;
      default:                is_fp = 1'b0;
    endcase
    return is_fp;
  endfunction

endpackage

// File: rtl/vx_tcu_drl_excep_apply_buf.sv
// Two-entry valid/ready FIFO with registered occupancy; ready on the write
// side depends only on the stored count, never on the read-side ready.
module VX_tcu_excep_buf #(
  parameter int DATA_W = 42,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    push     = in_valid & in_ready;
    pop      = out_valid & out_ready;
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = in_data;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Control state is reset; the payload storage is don't-care after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload register update.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/vx_tcu_drl_excep_apply.sv
// Applies FEDP exception overrides (canonical NaN / signed infinity) to the
// raw dot-product result, buffers it with its tag, and keeps saturating
// statistics of retired NaN and infinite results.
module vx_tcu_drl_excep_apply
  import VX_tcu_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [2:0]       fmtf,
  input  logic [31:0]      result_in,
  input  fedp_excep_t      excep_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [31:0]      result_out,
  output logic [TAG_W-1:0] tag_out,
  input  logic             clr_stats,
  output logic [15:0]      nan_cnt,
  output logic [15:0]      inf_cnt
);

  localparam int ENTRY_W = 2 + TAG_W + 32;

  logic               is_fp;
  logic               nan_flag, inf_flag;
  logic [31:0]        result_fix;
  logic [ENTRY_W-1:0] entry_in, entry_out;
  logic               head_nan, head_inf;
  logic               retire;
  logic [15:0]        nan_cnt_q, nan_cnt_d;
  logic [15:0]        inf_cnt_q, inf_cnt_d;

  // Exception override; NaN takes priority and integer formats pass through.
  always_comb begin
    is_fp      = tcu_is_fp_fmt(fmtf);
    nan_flag   = is_fp & excep_in.is_nan;
    inf_flag   = is_fp & excep_in.is_inf & ~excep_in.is_nan;
    result_fix = result_in;
    if (nan_flag)      result_fix = TCU_FP32_QNAN;
    else if (inf_flag) result_fix = {excep_in.sign, TCU_FP32_INF_MAG};
    entry_in   = {nan_flag, inf_flag, tag_in, result_fix};
  end

  VX_tcu_excep_buf #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) excep_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (valid_in),
    .in_ready  (ready_in),
    .in_data   (entry_in),
    .out_valid (valid_out),
    .out_ready (ready_out),
    .out_data  (entry_out)
  );

  assign head_nan   = entry_out[ENTRY_W-1];
  assign head_inf   = entry_out[ENTRY_W-2];
  assign tag_out    = entry_out[32 +: TAG_W];
  assign result_out = entry_out[31:0];
  assign retire     = valid_out & ready_out;

  // Saturating retirement statistics; clear overrides a coincident increment.
  always_comb begin
    nan_cnt_d = nan_cnt_q;
    inf_cnt_d = inf_cnt_q;
    if (clr_stats) begin
      nan_cnt_d = '0;
      inf_cnt_d = '0;
    end else if (retire) begin
      if (head_nan && nan_cnt_q != '1) nan_cnt_d = nan_cnt_q + 16'd1;
      if (head_inf && inf_cnt_q != '1) inf_cnt_d = inf_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      nan_cnt_q <= '0;
      inf_cnt_q <= '0;
    end else begin
      nan_cnt_q <= nan_cnt_d;
      inf_cnt_q <= inf_cnt_d;
    end
  end

  assign nan_cnt = nan_cnt_q;
  assign inf_cnt = inf_cnt_q;

endmodule

// File: tb/tb_vx_tcu_drl_excep_apply.sv
// Directed bench for vx_tcu_drl_excep_apply with hand-computed expectations.
module tb_vx_tcu_drl_excep_apply;
  import VX_tcu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_in;
  logic [2:0]  fmtf;
  logic [31:0] result_in;
  fedp_excep_t excep_in;
  logic [7:0]  tag_in;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] result_out;
  logic [7:0]  tag_out;
  logic        clr_stats;
  logic [15:0] nan_cnt;
  logic [15:0] inf_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_tcu_drl_excep_apply #(.TAG_W(8), .DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .fmtf       (fmtf),
    .result_in  (result_in),
    .excep_in   (excep_in),
    .tag_in     (tag_in),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .result_out (result_out),
    .tag_out    (tag_out),
    .clr_stats  (clr_stats),
    .nan_cnt    (nan_cnt),
    .inf_cnt    (inf_cnt)
  );

  // One clock; inputs set after this return apply at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] r,
                       input logic s, input logic n, input logic i, input logic [7:0] t);
    valid_in  = v;
    fmtf      = f;
    result_in = r;
    excep_in  = '{sign: s, is_nan: n, is_inf: i};
    tag_in    = t;
  endtask

  task automatic test_reset();
    reset = 1'b1; ready_out = 1'b0; clr_stats = 1'b0;
    drive(1'b0, TCU_FP32_ID, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    step(); step();
    reset = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
    checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready_in: got %b expected 1", ready_in); end
    checks++; if (nan_cnt !== 16'h0) begin errors++; $display("FAIL reset_nan_cnt: got %h expected 0000", nan_cnt); end
    checks++; if (inf_cnt !== 16'h0) begin errors++; $display("FAIL reset_inf_cnt: got %h expected 0000", inf_cnt); end
  endtask

  task automatic test_fp16_nan();
    ready_out = 1'b1;
    drive(1'b1, TCU_FP16_ID, 32'h3F800000, 1'b0, 1'b1, 1'b0, 8'h05);
    step();
    drive(1'b0, TCU_FP32_ID, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL fp16_nan_valid: got %b expected 1", valid_out); end
    checks++; if (result_out !== 32'h7FC00000) begin errors++; $display("FAIL fp16_nan_result: got %h expected 7fc00000", result_out); end
    checks++; if (tag_out !== 8'h05) begin errors++; $display("FAIL fp16_nan_tag: got %h expected 05", tag_out); end
    step();
    checks++; if (nan_cnt !== 16'd1) begin errors++; $display("FAIL fp16_nan_cnt: got %0d expected 1", nan_cnt); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL fp16_nan_drain: got %b expected 0", valid_out); end
  endtask

  task automatic test_bf8_inf_and_int();
    ready_out = 1'b1;
    drive(1'b1, TCU_BF8_ID, 32'h40490FDB, 1'b1, 1'b0, 1'b1, 8'h11);
    step();
    drive(1'b0, TCU_FP32_ID, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    checks++; if (result_out !== 32'hFF800000) begin errors++; $display("FAIL bf8_inf_result: got %h expected ff800000", result_out); end
    step();
    checks++; if (inf_cnt !== 16'd1) begin errors++; $display("FAIL bf8_inf_cnt: got %0d expected 1", inf_cnt); end
    checks++; if (nan_cnt !== 16'd1) begin errors++; $display("FAIL bf8_nan_cnt: got %0d expected 1", nan_cnt); end
    drive(1'b1, TCU_I8_ID, 32'h12345678, 1'b1, 1'b0, 1'b1, 8'h12);
    step();
    drive(1'b0, TCU_FP32_ID, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    checks++; if (result_out !== 32'h12345678) begin errors++; $display("FAIL int_raw_result: got %h expected 12345678", result_out); end
    step();
    checks++; if (inf_cnt !== 16'd1) begin errors++; $display("FAIL int_inf_cnt: got %0d expected 1", inf_cnt); end
    checks++; if (nan_cnt !== 16'd1) begin errors++; $display("FAIL int_nan_cnt: got %0d expected 1", nan_cnt); end
  endtask

  task automatic test_both_flags();
    ready_out = 1'b1;
    drive(1'b1, TCU_FP32_ID, 32'hC0000000, 1'b1, 1'b1, 1'b1, 8'h20);
    step();
    drive(1'b0, TCU_FP32_ID, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    checks++; if (result_out !== 32'h7FC00000) begin errors++; $display("FAIL both_result: got %h expected 7fc00000", result_out); end
    step();
    checks++; if (nan_cnt !== 16'd2) begin errors++; $display("FAIL both_nan_cnt: got %0d expected 2", nan_cnt); end
    checks++; if (inf_cnt !== 16'd1) begin errors++; $display("FAIL both_inf_cnt: got %0d expected 1", inf_cnt); end
  endtask

  task automatic test_back_to_back();
    ready_out = 1'b0;
    drive(1'b1, TCU_FP32_ID, 32'hA0000000, 1'b0, 1'b0, 1'b0, 8'd0);
    step();
    checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL b2b_ready_after1: got %b expected 1", ready_in); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL b2b_valid_after1: got %b expected 1", valid_out); end
    drive(1'b1, TCU_FP32_ID, 32'hA0000001, 1'b0, 1'b0, 1'b0, 8'd1);
    step();
    checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b expected 0", ready_in); end
    drive(1'b1, TCU_FP32_ID, 32'hA0000002, 1'b0, 1'b0, 1'b0, 8'd2);
    step();
    checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL b2b_ready_stall: got %b expected 0", ready_in); end
    checks++; if (tag_out !== 8'd0) begin errors++; $display("FAIL b2b_hold_tag: got %0d expected 0", tag_out); end
    checks++; if (result_out !== 32'hA0000000) begin errors++; $display("FAIL b2b_hold_result: got %h expected a0000000", result_out); end
    ready_out = 1'b1;
    #1;
    checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL b2b_ready_no_comb: got %b expected 0", ready_in); end
    step();
    checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL b2b_ready_return: got %b expected 1", ready_in); end
    checks++; if (tag_out !== 8'd1) begin errors++; $display("FAIL b2b_order1: got %0d expected 1", tag_out); end
    step();
    drive(1'b0, TCU_FP32_ID, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    checks++; if (tag_out !== 8'd2) begin errors++; $display("FAIL b2b_order2: got %0d expected 2", tag_out); end
    checks++; if (result_out !== 32'hA0000002) begin errors++; $display("FAIL b2b_result2: got %h expected a0000002", result_out); end
    step();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", valid_out); end
    checks++; if (nan_cnt !== 16'd2) begin errors++; $display("FAIL b2b_nan_cnt: got %0d expected 2", nan_cnt); end
  endtask

  task automatic test_saturation();
    ready_out = 1'b1;
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    checks++; if (nan_cnt !== 16'd0) begin errors++; $display("FAIL sat_clear: got %0d expected 0", nan_cnt); end
    drive(1'b1, TCU_FP8_ID, 32'h1, 1'b0, 1'b1, 1'b0, 8'h33);
    repeat (65535) step();
    drive(1'b0, TCU_FP32_ID, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    step(); step();
    checks++; if (nan_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_preload: got %h expected ffff", nan_cnt); end
    drive(1'b1, TCU_BF16_ID, 32'h2, 1'b0, 1'b1, 1'b0, 8'h34);
    step();
    drive(1'b0, TCU_FP32_ID, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    step();
    checks++; if (nan_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", nan_cnt); end
    drive(1'b1, TCU_FP16_ID, 32'h3, 1'b0, 1'b1, 1'b0, 8'h35);
    step();
    drive(1'b0, TCU_FP32_ID, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL sat_clr_head: got %b expected 1", valid_out); end
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    checks++; if (nan_cnt !== 16'd0) begin errors++; $display("FAIL sat_clr_wins: got %h expected 0000", nan_cnt); end
    step();
    checks++; if (nan_cnt !== 16'd0) begin errors++; $display("FAIL sat_clr_stays: got %h expected 0000", nan_cnt); end
  endtask

  task automatic test_reset_mid();
    ready_out = 1'b1;
    drive(1'b1, TCU_FP16_ID, 32'h5, 1'b0, 1'b0, 1'b1, 8'h40);
    step();
    drive(1'b0, TCU_FP32_ID, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    step();
    checks++; if (inf_cnt !== 16'd1) begin errors++; $display("FAIL mid_pre_inf: got %0d expected 1", inf_cnt); end
    ready_out = 1'b0;
    drive(1'b1, TCU_FP32_ID, 32'h6, 1'b0, 1'b1, 1'b0, 8'h41);
    step();
    drive(1'b1, TCU_FP32_ID, 32'h7, 1'b0, 1'b0, 1'b1, 8'h42);
    step();
    checks++; if (ready_in !== 1'b0) begin errors++; $display("FAIL mid_full: got %b expected 0", ready_in); end
    reset = 1'b1;
    ready_out = 1'b1;
    drive(1'b1, TCU_FP32_ID, 32'h8, 1'b0, 1'b1, 1'b0, 8'h43);
    step();
    reset = 1'b0;
    drive(1'b0, TCU_FP32_ID, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_valid_out: got %b expected 0", valid_out); end
    checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL mid_ready_in: got %b expected 1", ready_in); end
    checks++; if (nan_cnt !== 16'd0) begin errors++; $display("FAIL mid_nan_cnt: got %0d expected 0", nan_cnt); end
    checks++; if (inf_cnt !== 16'd0) begin errors++; $display("FAIL mid_inf_cnt: got %0d expected 0", inf_cnt); end
    step();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %b expected 0", valid_out); end
    drive(1'b1, TCU_I32_ID, 32'h99, 1'b0, 1'b1, 1'b1, 8'h09);
    step();
    drive(1'b0, TCU_FP32_ID, 32'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    checks++; if (tag_out !== 8'h09) begin errors++; $display("FAIL mid_new_tag: got %h expected 09", tag_out); end
    checks++; if (result_out !== 32'h99) begin errors++; $display("FAIL mid_new_result: got %h expected 00000099", result_out); end
    step();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_new_drain: got %b expected 0", valid_out); end
    checks++; if (nan_cnt !== 16'd0) begin errors++; $display("FAIL mid_int_nan_cnt: got %0d expected 0", nan_cnt); end
  endtask

  initial begin
    test_reset();
    test_fp16_nan();
    test_bf8_inf_and_int();
    test_both_flags();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
